fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Receiving end of the PC/instruction-fetch interface.
- Captures each issued PC and the instruction word that returns from synchronous-read instruction memory one cycle later.
- Buffers {pc, instr} pairs in a small in-order queue that decode drains with valid/ready.
- Back-pressures the PC register via stallPC and discards everything on a redirect flush.

Parameters:
ADDR_WIDTH, 12, width of PC/address
DATA_WIDTH, 32, instruction word width
DEPTH, 4, queue entries (power of 2, >=2)
OFFSET, 4, increment used for outIncPC

Ports:
clk  input  1  clock, all state updates on posedge
triggerRstN  input  1  synchronous, active-low reset
pc  input  ADDR_WIDTH  address issued to instruction memory this cycle
fetchEn  input  1  a fetch is issued at pc this cycle
instr  input  DATA_WIDTH  memory read data, valid the cycle after issue
flush  input  1  redirect; kill queue and in-flight fetch
stallPC  output  1  PC register must hold (no new fetch accepted)
outValid  output  1  head entry valid
outReady  input  1  decode accepts head
outPC  output  ADDR_WIDTH  head PC
outInstr  output  DATA_WIDTH  head instruction
outIncPC  output  ADDR_WIDTH  outPC + OFFSET, truncated to ADDR_WIDTH
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, on triggerRstN, evaluated at posedge clk.
- Reset state: count=0, rd/wr pointers=0, pendValid=0, outValid=0, stallPC=0, outPC=0, outInstr=0, outIncPC=OFFSET. Reset overrides flush, push and pop.
- Issue: fetch accepted iff fetchEn && !stallPC && !flush. On acceptance, pendValid<=1 and pendPC<=pc; otherwise pendValid<=0.
- Push: when pendValid=1 and flush=0, {pendPC, instr} is written at wrPtr and wrPtr increments mod DEPTH.
- Pop: when outValid && outReady && !flush, rdPtr increments mod DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: issue in cycle N, instr sampled in N+1, entry visible (outValid=1) in N+2. There is no bypass in the base configuration.
- stallPC = (count + pendValid) >= DEPTH. It is combinational from registered state only, with no path from outReady. This guarantees a push never overflows, and count==DEPTH implies pendValid==0.
- outValid = (count != 0). outPC/outInstr present the head entry when outValid=1 and are forced to 0 when outValid=0.
- Flush (priority over push/pop): next cycle count=0, pointers=0, pendValid=0, outValid=0. The fetch presented in the flush cycle is not accepted. instr arriving the cycle after the flush is ignored. A handshake in the flush cycle is not counted.
- Wrap-around: pointers wrap silently at DEPTH. Ordering is strictly FIFO.
- fetchEn while stallPC=1: ignored, no state change from the issue path.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined, and count==0 and pendValid=1 and no flush: {pendPC, instr} drives the outputs combinationally in cycle N+1 with outValid=1.
  - If outReady=1 that cycle, the entry is consumed and not written; count stays 0.
  - If outReady=0, it is pushed as normal.
- Undefined: latency is exactly 2 cycles as above.
- stallPC is unchanged in both builds.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t (packed struct {pc, instr})
  - default DEPTH
  - NOP_INSTR = 32'h00000013 (for downstream bubble insertion)
- One natural sub-module, fetch_fifo:
  - storage, pointers, count, flush clear
  - parameterised by entry type and DEPTH
- fetch_queue adds the in-flight register, stall logic, bypass and output gating.

Test Plan:
1. Reset: hold triggerRstN=0 2 cycles with fetchEn=1, pc=0x010 -> outValid=0, stallPC=0, count=0, outPC=0, outIncPC=0x004. No entry appears after release.
2. Single fetch: pc=0x004 with fetchEn=1 in N, instr=0x00500093 in N+1 -> in N+2 outValid=1, outPC=0x004, outInstr=0x00500093, outIncPC=0x008. outReady=1 -> count=0 in N+3.
3. Fill/stall: outReady=0, issue pc 0x000,0x004,0x008,0x00C back-to-back -> stallPC=1 the cycle after 0x00C issues and further fetchEn is ignored. One pop -> stallPC=0 next cycle; drained order is 0x000,0x004,0x008,0x00C.
4. Flush: 2 entries queued plus 1 pending, assert flush -> next cycle count=0, outValid=0 and the trailing instr is dropped. A fetch at pc=0x100 afterwards -> only 0x100 is delivered.
5. Reset mid-operation: 3 entries queued, triggerRstN=0 for 1 cycle -> all outputs at reset values next cycle, no stale entry after release.
6. Wrap-around: stream 10 sequential PCs from 0x000 with outReady toggling 1,0 -> output sequence 0x000..0x024 with no loss or duplication. Under FETCH_QUEUE_BYPASS_EN with outReady=1 constantly, each entry appears at N+1 and count stays 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue.
// Holds the default geometry, the {pc, instr} entry type and the NOP
// encoding that downstream stages use to insert bubbles.
package fetch_pkg;

    localparam int FQ_ADDR_WIDTH = 12;
    localparam int FQ_DATA_WIDTH = 32;
    localparam int FQ_DEPTH      = 4;

    // addi x0, x0, 0 : bubble word for decode when nothing is valid
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FQ_ADDR_WIDTH-1:0] pc;
        logic [FQ_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Width of an occupancy counter that can hold 0..depth inclusive
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signal bundle of the fetch queue.
//
// Handshakes:
//   Issue side: a fetch is taken at pc in any cycle where fetchEn=1,
//   stallPC=0 and flush=0; the matching instr is presented exactly one
//   cycle later with no valid of its own.
//   Decode side: outValid/outReady. The head moves when both are 1 at a
//   posedge (and flush=0); outValid never depends on outReady and, once
//   high, the head holds until taken or flushed.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic [ADDR_WIDTH-1:0]    pc;
    logic                     fetchEn;
    logic [DATA_WIDTH-1:0]    instr;
    logic                     flush;
    logic                     stallPC;
    logic                     outValid;
    logic                     outReady;
    logic [ADDR_WIDTH-1:0]    outPC;
    logic [DATA_WIDTH-1:0]    outInstr;
    logic [ADDR_WIDTH-1:0]    outIncPC;
    logic [$clog2(DEPTH):0]   count;

    // The queue itself
    modport slave (
        input  pc, fetchEn, instr, flush, outReady,
        output stallPC, outValid, outPC, outInstr, outIncPC, count
    );

    // Fetch unit / decode stage side
    modport master (
        output pc, fetchEn, instr, flush, outReady,
        input  stallPC, outValid, outPC, outInstr, outIncPC, count
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// In-order storage for fetch entries: array, read/write pointers and an
// occupancy count. Flush empties it in one cycle. Pointers wrap at DEPTH,
// which must be a power of two. Callers never push when full or pop when
// empty; the queue's stall logic guarantees that.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = FQ_DEPTH,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic [CW-1:0] count
);

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Next-state: flush wins, otherwise apply push and pop independently
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Receiving end of the PC / instruction-fetch path.
// Tracks the one fetch in flight (pc issued last cycle, instr arriving
// now), pushes {pc, instr} into an in-order queue and presents the head
// to decode. stallPC holds the PC register when queue + in-flight would
// reach DEPTH, so a push can never overflow.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- when the queue is empty
// the arriving entry is shown to decode in the same cycle it arrives and
// is not stored if decode takes it immediately.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = FQ_ADDR_WIDTH,
    parameter int DATA_WIDTH = FQ_DATA_WIDTH,
    parameter int DEPTH      = FQ_DEPTH,
    parameter int OFFSET     = 4
) (
    input  logic          clk,
    input  logic          triggerRstN,
    fetch_queue_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic                  pend_valid_q, pend_valid_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic [CW-1:0]         fifo_count;
    entry_t                fifo_rdata;
    entry_t                arrive_entry;
    entry_t                head;
    logic                  fifo_nonempty;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  out_valid;
    logic                  stall;
    logic                  accept;
    logic [CW:0]           occupancy;
    logic [ADDR_WIDTH-1:0] out_pc;

    // Bypass is legal only when nothing older sits in the queue
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = !fifo_nonempty && pend_valid_q && !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // Stall from registered occupancy only, never from outReady
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pend_valid_q};
        stall     = occupancy >= (CW+1)'(DEPTH);
    end

    // Issue path, queue control and head selection
    always_comb begin
        fifo_nonempty = fifo_count != '0;
        accept        = bus.fetchEn && !stall && !bus.flush;
        pend_valid_d  = accept;
        pend_pc_d     = accept ? bus.pc : pend_pc_q;
        arrive_entry  = '{pc: pend_pc_q, instr: bus.instr};
        push          = pend_valid_q && !bus.flush && !(bypass && bus.outReady);
        pop           = fifo_nonempty && bus.outReady && !bus.flush;
        out_valid     = fifo_nonempty || bypass;
        head          = bypass ? arrive_entry : fifo_rdata;
    end

    // Decode-facing outputs, zeroed whenever nothing is valid
    always_comb begin
        out_pc        = out_valid ? head.pc : '0;
        bus.outValid  = out_valid;
        bus.outPC     = out_pc;
        bus.outInstr  = out_valid ? head.instr : '0;
        bus.outIncPC  = out_pc + ADDR_WIDTH'(OFFSET);
        bus.stallPC   = stall;
        bus.count     = fifo_count;
    end

    // In-flight fetch register; reset dominates everything
    always_ff @(posedge clk) begin
        if (!triggerRstN) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (triggerRstN),
        .flush (bus.flush),
        .push  (push),
        .wdata (arrive_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

endmodule
